// File: rtl/decoder.sv
// Main instruction decoder for the ARM-subset CPU; outputs registered once.
// Optional ADC command support is enabled by defining DECODER_ADC_EN.
module decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       reg_w,
  output logic       mem_w,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       no_write,
  output logic       shift,
  output logic [1:0] flag_w,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [2:0] alu_ctl
);

  localparam logic [1:0] OpData   = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;

  logic       pcs_d, reg_w_d, mem_w_d, mem_to_reg_d, alu_src_d, no_write_d, shift_d;
  logic [1:0] flag_w_d, imm_src_d, reg_src_d;
  logic [2:0] alu_ctl_d;

  logic       cmd_ok, cmd_arith, cmd_test;
  logic [3:0] cmd;

  assign cmd = funct[4:1];

  always_comb begin
    reg_w_d      = 1'b0;
    mem_w_d      = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_d    = 1'b0;
    no_write_d   = 1'b0;
    shift_d      = 1'b0;
    flag_w_d     = 2'b00;
    imm_src_d    = 2'b00;
    reg_src_d    = 2'b00;
    alu_ctl_d    = 3'b000;
    cmd_ok       = 1'b1;
    cmd_arith    = 1'b0;
    cmd_test     = 1'b0;

    case (op)
      OpData: begin
        alu_src_d = funct[5];
        case (cmd)
          4'b0100: begin alu_ctl_d = 3'b000; cmd_arith = 1'b1; end
          4'b0010: begin alu_ctl_d = 3'b001; cmd_arith = 1'b1; end
          4'b0000: alu_ctl_d = 3'b010;
          4'b1100: alu_ctl_d = 3'b011;
`ifdef DECODER_ADC_EN
          4'b0101: begin alu_ctl_d = 3'b100; cmd_arith = 1'b1; end
`endif
          4'b1101: begin alu_ctl_d = 3'b101; shift_d = 1'b1; end
          4'b1010: begin alu_ctl_d = 3'b001; cmd_arith = 1'b1; cmd_test = 1'b1; end
          4'b1011: begin alu_ctl_d = 3'b000; cmd_arith = 1'b1; cmd_test = 1'b1; end
          4'b1000: begin alu_ctl_d = 3'b010; cmd_test = 1'b1; end
          default: cmd_ok = 1'b0;
        endcase
        // Unsupported commands collapse to a flag-less, write-less no-op.
        if (cmd_ok) begin
          no_write_d = cmd_test;
          flag_w_d   = {funct[0], funct[0] & cmd_arith};
        end else begin
          no_write_d = 1'b1;
          alu_ctl_d  = 3'b000;
          shift_d    = 1'b0;
        end
        reg_w_d = ~no_write_d;
      end
      OpMem: begin
        alu_src_d = 1'b1;
        imm_src_d = 2'b01;
        if (funct[0]) begin
          reg_w_d      = 1'b1;
          mem_to_reg_d = 1'b1;
        end else begin
          mem_w_d   = 1'b1;
          reg_src_d = 2'b10;
        end
      end
      OpBranch: begin
        alu_src_d = 1'b1;
        imm_src_d = 2'b10;
        reg_src_d = 2'b01;
      end
      default: ;
    endcase

    pcs_d = (reg_w_d && (rd == 4'hF)) || (op == OpBranch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcs        <= 1'b0;
      reg_w      <= 1'b0;
      mem_w      <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_src    <= 1'b0;
      no_write   <= 1'b0;
      shift      <= 1'b0;
      flag_w     <= 2'b00;
      imm_src    <= 2'b00;
      reg_src    <= 2'b00;
      alu_ctl    <= 3'b000;
    end else begin
      pcs        <= pcs_d;
      reg_w      <= reg_w_d;
      mem_w      <= mem_w_d;
      mem_to_reg <= mem_to_reg_d;
      alu_src    <= alu_src_d;
      no_write   <= no_write_d;
      shift      <= shift_d;
      flag_w     <= flag_w_d;
      imm_src    <= imm_src_d;
      reg_src    <= reg_src_d;
      alu_ctl    <= alu_ctl_d;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed vector table, reset sequences and random
// stimulus against a table-lookup reference model.
module tb_decoder;

  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       no_write;
    logic       shift;
    logic [1:0] flag_w;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu_ctl;
  } outs_t;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    outs_t      exp;
  } vec_t;

  typedef struct {
    logic [3:0] cmd;
    logic [2:0] alu;
    bit         arith;
    bit         test;
    bit         mov;
    bit         adc;
  } dp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs, reg_w, mem_w, mem_to_reg, alu_src, no_write, shift;
  logic [1:0] flag_w, imm_src, reg_src;
  logic [2:0] alu_ctl;

  int errors = 0;
  int checks = 0;

  vec_t vecs[22];
  dp_t  dp_tab[9];

  decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct     (funct),
    .rd        (rd),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .mem_to_reg(mem_to_reg),
    .alu_src   (alu_src),
    .no_write  (no_write),
    .shift     (shift),
    .flag_w    (flag_w),
    .imm_src   (imm_src),
    .reg_src   (reg_src),
    .alu_ctl   (alu_ctl)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic p, input logic rw, input logic mw, input logic m2r,
                               input logic as, input logic nw, input logic sh,
                               input logic [1:0] fw, input logic [1:0] is,
                               input logic [1:0] rs, input logic [2:0] alu);
    outs_t o;
    o = '{pcs: p, reg_w: rw, mem_w: mw, mem_to_reg: m2r, alu_src: as, no_write: nw,
          shift: sh, flag_w: fw, imm_src: is, reg_src: rs, alu_ctl: alu};
    return o;
  endfunction

  // Reference: look the command up in a table of supported data-processing ops.
  function automatic outs_t model(input logic [1:0] o_op, input logic [5:0] f,
                                  input logic [3:0] r);
    outs_t o;
    int    hit;
    bit    adc_en;
    o = '0;
    hit = -1;
`ifdef DECODER_ADC_EN
    adc_en = 1'b1;
`else
    adc_en = 1'b0;
`endif
    if (o_op == 2'd0) begin
      for (int i = 0; i < 9; i++)
        if (dp_tab[i].cmd == f[4:1] && (!dp_tab[i].adc || adc_en)) hit = i;
      o.alu_src = f[5];
      if (hit < 0) begin
        o.no_write = 1'b1;
      end else begin
        o.alu_ctl  = dp_tab[hit].alu;
        o.no_write = dp_tab[hit].test;
        o.shift    = dp_tab[hit].mov;
        o.reg_w    = !dp_tab[hit].test;
        o.flag_w   = {f[0], f[0] && dp_tab[hit].arith};
      end
    end else if (o_op == 2'd1) begin
      o.alu_src    = 1'b1;
      o.imm_src    = 2'd1;
      o.reg_w      = f[0];
      o.mem_to_reg = f[0];
      o.mem_w      = !f[0];
      o.reg_src    = f[0] ? 2'd0 : 2'd2;
    end else if (o_op == 2'd2) begin
      o.alu_src = 1'b1;
      o.imm_src = 2'd2;
      o.reg_src = 2'd1;
    end
    o.pcs = (o.reg_w && r == 4'd15) || o_op == 2'd2;
    return o;
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t got;
    got = '{pcs: pcs, reg_w: reg_w, mem_w: mem_w, mem_to_reg: mem_to_reg, alu_src: alu_src,
            no_write: no_write, shift: shift, flag_w: flag_w, imm_src: imm_src,
            reg_src: reg_src, alu_ctl: alu_ctl};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (pcs rw mw m2r as nw sh fw is rs alu)",
               name, got, exp);
    end
  endtask

  task automatic apply(input logic [1:0] o_op, input logic [5:0] f, input logic [3:0] r);
    @(negedge clk);
    op = o_op;
    funct = f;
    rd = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    outs_t adc_exp, adcs_exp, noop;
    dp_tab[0] = '{4'b0100, 3'd0, 1, 0, 0, 0};
    dp_tab[1] = '{4'b0010, 3'd1, 1, 0, 0, 0};
    dp_tab[2] = '{4'b0000, 3'd2, 0, 0, 0, 0};
    dp_tab[3] = '{4'b1100, 3'd3, 0, 0, 0, 0};
    dp_tab[4] = '{4'b0101, 3'd4, 1, 0, 0, 1};
    dp_tab[5] = '{4'b1101, 3'd5, 0, 0, 1, 0};
    dp_tab[6] = '{4'b1010, 3'd1, 1, 1, 0, 0};
    dp_tab[7] = '{4'b1011, 3'd0, 1, 1, 0, 0};
    dp_tab[8] = '{4'b1000, 3'd2, 0, 1, 0, 0};

    noop = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000);
`ifdef DECODER_ADC_EN
    adc_exp  = mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b100);
    adcs_exp = mk(0, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b100);
`else
    adc_exp  = noop;
    adcs_exp = noop;
`endif
    vecs[0]  = '{"add",      2'b00, 6'b001000, 4'd0,  mk(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000)};
    vecs[1]  = '{"sub",      2'b00, 6'b000100, 4'd0,  mk(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b001)};
    vecs[2]  = '{"and",      2'b00, 6'b000000, 4'd0,  mk(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b010)};
    vecs[3]  = '{"orr",      2'b00, 6'b011000, 4'd0,  mk(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b011)};
    vecs[4]  = '{"adc",      2'b00, 6'b001010, 4'd0,  adc_exp};
    vecs[5]  = '{"and_imm",  2'b00, 6'b100000, 4'd0,  mk(0,1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b010)};
    vecs[6]  = '{"adds",     2'b00, 6'b001001, 4'd0,  mk(0,1,0,0,0,0,0,2'b11,2'b00,2'b00,3'b000)};
    vecs[7]  = '{"ands",     2'b00, 6'b000001, 4'd0,  mk(0,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'b010)};
    vecs[8]  = '{"cmp_s",    2'b00, 6'b010101, 4'd0,  mk(0,0,0,0,0,1,0,2'b11,2'b00,2'b00,3'b001)};
    vecs[9]  = '{"mov_s",    2'b00, 6'b011011, 4'd0,  mk(0,1,0,0,0,0,1,2'b10,2'b00,2'b00,3'b101)};
    vecs[10] = '{"str",      2'b01, 6'b000000, 4'd0,  mk(0,0,1,0,1,0,0,2'b00,2'b01,2'b10,3'b000)};
    vecs[11] = '{"ldr",      2'b01, 6'b000001, 4'd0,  mk(0,1,0,1,1,0,0,2'b00,2'b01,2'b00,3'b000)};
    vecs[12] = '{"and_r15",  2'b00, 6'b000000, 4'd15, mk(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b010)};
    vecs[13] = '{"and_r14",  2'b00, 6'b000000, 4'd14, mk(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b010)};
    vecs[14] = '{"branch",   2'b10, 6'b000000, 4'd0,  mk(1,0,0,0,1,0,0,2'b00,2'b10,2'b01,3'b000)};
    vecs[15] = '{"undef",    2'b11, 6'b111111, 4'd15, '0};
    vecs[16] = '{"cmp_r15",  2'b00, 6'b010101, 4'd15, mk(0,0,0,0,0,1,0,2'b11,2'b00,2'b00,3'b001)};
    vecs[17] = '{"unsup_r15",2'b00, 6'b001110, 4'd15, noop};
    vecs[18] = '{"ldr_r15",  2'b01, 6'b000001, 4'd15, mk(1,1,0,1,1,0,0,2'b00,2'b01,2'b00,3'b000)};
    vecs[19] = '{"str_r15",  2'b01, 6'b000000, 4'd15, mk(0,0,1,0,1,0,0,2'b00,2'b01,2'b10,3'b000)};
    vecs[20] = '{"branch_f", 2'b10, 6'b111111, 4'd15, mk(1,0,0,0,1,0,0,2'b00,2'b10,2'b01,3'b000)};
    vecs[21] = '{"adc_s",    2'b00, 6'b001011, 4'd0,  adcs_exp};

    // Reset holds outputs at zero with active decode inputs and clock edges.
    rst_n = 1'b0;
    op = 2'b00;
    funct = 6'b001001;
    rd = 4'd15;
    #2;
    check("rst_async", '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold", '0);
    @(negedge clk);
    rst_n = 1'b1;
    funct = 6'b001000;
    rd = 4'd0;
    #1;
    check("rst_release", '0);
    @(posedge clk);
    #1;
    check("rst_first", mk(0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000));

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].funct, vecs[i].rd);
      check(vecs[i].name, vecs[i].exp);
    end

    // Mid-stream reset discards the registered decode immediately.
    apply(2'b10, 6'b000000, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", '0);
    @(posedge clk);
    #1;
    check("rst_mid_hold", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_release", '0);
    @(posedge clk);
    #1;
    check("rst_mid_resume", model(2'b10, 6'b000000, 4'd0));

    // Back-to-back random decodes; every cycle is checked.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] r_op;
      logic [5:0] r_f;
      logic [3:0] r_rd;
      r_op = 2'($urandom_range(0, 3));
      r_f  = 6'($urandom_range(0, 63));
      r_rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      apply(r_op, r_f, r_rd);
      check($sformatf("rand%0d_op%0d_f%0h_rd%0d", n, r_op, r_f, r_rd), model(r_op, r_f, r_rd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
